fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  one-cycle pulse requesting the instruction word at imem_addr.
REQ-005 imem_addr  output  16  byte address of the requested word; equals current PC.
REQ-006 imem_rdy  input  1  response strobe; latency at least 1 cycle after imem_req.
REQ-007 imem_data  input  16  instruction word, valid only when imem_rdy=1.
REQ-008 redirect  input  1  branch/jump taken; overrides the sequential PC.
REQ-009 redirect_pc  input  16  target address, sampled when redirect=1.
REQ-010 stall  input  1  decode cannot accept; if_* outputs held.
REQ-011 if_valid  output  1  if_instr/if_pc/if_pc_plus2 are meaningful.
REQ-012 if_instr  output  16  fetched word; bits [15:11] are the opcode consumed by decode.
REQ-013 if_pc, if_pc_plus2  output  16 each  address of if_instr and that address + 2.
REQ-014 halted  output  1  high once the HALT word has been delivered.

Function
REQ-015 FSM states SHALL be FETCH, WAIT, HOLD, SQUASH, HALTED.
REQ-016 Slot free SHALL mean (!if_valid || !stall); a transfer occurs on any edge with if_valid=1 and stall=0, clearing if_valid unless reloaded in the same cycle.
REQ-017 FETCH: when the slot is free and redirect=0, assert imem_req with imem_addr=PC and go to WAIT; otherwise remain in FETCH with imem_req=0.
REQ-018 WAIT, imem_rdy=1, slot free: load if_instr=imem_data, if_pc=PC, if_pc_plus2=PC+2, if_valid=1; PC <= PC+2; next state FETCH, or HALTED if imem_data[15:11]=5'b00000.
REQ-019 WAIT, imem_rdy=1, slot not free: capture the word and its PC in a one-entry pending buffer; PC <= PC+2; go to HOLD.
REQ-020 HOLD: on the first cycle the slot is free, move the pending entry into the if_* registers and go to FETCH, or HALTED if its opcode is 5'b00000.
REQ-021 PC+2 SHALL wrap modulo 2^16 (16'hFFFE + 2 = 16'h0000).
REQ-022 redirect=1 in FETCH, WAIT, or HOLD SHALL set PC <= redirect_pc, clear if_valid, and discard the pending entry.
REQ-023 Redirect-driven next state SHALL be: from WAIT with imem_rdy=0, SQUASH; from WAIT with imem_rdy=1, FETCH with the response discarded; otherwise FETCH.
REQ-024 SQUASH: keep imem_req=0; the next imem_rdy SHALL be discarded, then go to FETCH; a further redirect in SQUASH updates PC only.
REQ-025 Redirect SHALL take priority over halt detection and over imem_rdy in the same cycle.
REQ-026 HALTED: no requests; redirect ignored; halted=1; the HALT word remains presented until consumed; the state is left only by rst.
REQ-027 Opcode 5'b00001 (NOP) and all other opcodes SHALL pass through unmodified.
REQ-028 At most one imem request SHALL be outstanding at any time.

Reset
REQ-029 While rst=1, at the clock edge: PC=RESET_PC, state=FETCH, if_valid=0, pending entry empty, halted=0, if_instr/if_pc/if_pc_plus2=16'h0000.
REQ-030 While rst=1, imem_req SHALL be 0.
REQ-031 rst mid-WAIT SHALL abandon the outstanding request; a stale imem_rdy arriving before the first post-reset imem_req SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold OP_HALT=5'b00000, OP_NOP=5'b00001, the FSM state encoding, and the RESET_PC default, so the instruction decoder uses the same opcode constants.
REQ-033 One sub-module, pc_reg, SHALL hold the PC (sync reset, load-enable, redirect mux, +2 incrementer); all other logic stays in fetch_stage.

Verification
REQ-034 Reset, then imem latency 1 returning 16'h4000, 16'h4800: if_pc sequence 0000, 0002; if_pc_plus2 0002, 0004.
REQ-035 stall=1 held 3 cycles while the response 16'h0800 arrives: HOLD entered, if_* unchanged; after stall drops, if_instr=16'h0800 with no imem_req issued during the stall.
REQ-036 redirect with redirect_pc=16'h0100 while in WAIT, response arriving 2 cycles later: response dropped; next imem_addr=16'h0100.
REQ-037 Response 16'h0000 (HALT): if_valid=1 with if_instr=16'h0000, halted=1, no further imem_req; redirect then ignored.
REQ-038 RESET_PC=16'hFFFE: fetches 16'hFFFE then 16'h0000; if_pc_plus2 of the first word is 16'h0000.
REQ-039 rst asserted mid-WAIT, stale imem_rdy on the next cycle: if_valid stays 0; first imem_addr after reset is RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Constants and types shared by the fetch stage and the instruction decoder:
// opcode values, fetch FSM encoding and the default reset PC.
package fetch_stage_pkg;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_SQUASH = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_t;

    // One instruction slot: the word plus the two addresses travelling with it.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_plus2;
    } if_word_t;

    function automatic logic [4:0] opcode_of(input logic [15:0] instr);
        return instr[15:11];
    endfunction

    function automatic logic is_halt(input logic [15:0] instr);
        return opcode_of(instr) == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: synchronous reset, redirect mux and a +2 incrementer that
// wraps modulo 2^16.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2
);

    assign pc_plus2 = pc + 16'd2;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, matching real hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (advance) begin
            pc <= pc_plus2;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one imem request at a time, presents fetched
// words to decode with a one-entry skid buffer, honours redirects and HALT.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        halted
);

    fetch_state_t state;
    fetch_state_t load_next;
    if_word_t     slot_word;
    if_word_t     pend_word;
    if_word_t     rsp_word;
    if_word_t     load_word;
    logic [15:0]  pc;
    logic [15:0]  pc_plus2;
    logic         slot_free;
    logic         redirect_take;
    logic         rsp_accept;
    logic         pend_capture;
    logic         load_slot;
    logic         load_halt;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .advance     (rsp_accept),
        .redirect    (redirect_take),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc_plus2    (pc_plus2)
    );

    assign slot_free     = !if_valid || !stall;
    assign redirect_take = redirect && (state != ST_HALTED);

    // A response in WAIT is kept unless a redirect lands in the same cycle.
    assign rsp_accept    = (state == ST_WAIT) && imem_rdy && !redirect;
    assign pend_capture  = rsp_accept && !slot_free;
    assign load_slot     = slot_free && (rsp_accept || ((state == ST_HOLD) && !redirect));

    assign rsp_word      = {imem_data, pc, pc_plus2};
    assign load_word     = (state == ST_HOLD) ? pend_word : rsp_word;
    assign load_halt     = is_halt(load_word.instr);
    assign load_next     = load_halt ? ST_HALTED : ST_FETCH;

    assign imem_req      = !rst && (state == ST_FETCH) && slot_free && !redirect;
    assign imem_addr     = pc;

    assign if_instr      = slot_word.instr;
    assign if_pc         = slot_word.pc;
    assign if_pc_plus2   = slot_word.pc_plus2;

    // NOTE: the pending entry is plain data qualified by the HOLD state, so it
    // carries no reset; only control state needs a defined value out of reset.
    always_ff @(posedge clk) begin
        if (pend_capture) begin
            pend_word <= rsp_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            if_valid  <= 1'b0;
            slot_word <= '0;
            halted    <= 1'b0;
        end else begin
            // Decode takes the word on any unstalled edge; a reload below wins.
            if (if_valid && !stall) begin
                if_valid <= 1'b0;
            end

            case (state)
                ST_FETCH: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                    end else if (slot_free) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        state    <= imem_rdy ? ST_FETCH : ST_SQUASH;
                    end else if (imem_rdy) begin
                        state <= slot_free ? load_next : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        state    <= ST_FETCH;
                    end else if (slot_free) begin
                        state <= load_next;
                    end
                end
                ST_SQUASH: begin
                    if (imem_rdy) begin
                        state <= ST_FETCH;
                    end
                end
                ST_HALTED: begin
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase

            if (load_slot) begin
                if_valid  <= 1'b1;
                slot_word <= load_word;
                if (load_halt) begin
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule
